barrett_reduce_pipe: RTL and testbench

- Pipelined, parametrised Barrett modular reducer: out_data = in_data mod Q, exact.
- Successor to the combinational 32-bit/mod-3329 reducer inside the NTT butterfly datapath.
- Adds generic width and modulus, a 3-stage pipeline, valid/ready handshake with backpressure, and a sideband tag so the NTT controller can track coefficient indices.

---
 rtl/barrett_reduce_pipe.sv | 161 ++++++++++++++++
 tb/tb_barrett_reduce_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrett_reduce_pipe.sv
// barrett_reduce_pipe
// Three-stage pipelined Barrett reducer: out_data = in_data mod Q, exact.
//   S1: capture operand c, tag, and the full product p = c * M
//   S2: quotient estimate qe = p >> K, partial remainder r = c - qe*Q (0 <= r < 2Q)
//   S3: single conditional subtraction of Q
// A single global enable advances all stages. The enable drops only while a
// valid result is waiting on out_ready. Bubbles travel through the pipe and
// are not collapsed.
// Optional: define BARRETT_REDUCE_STATS_EN to add the done_count/stats_clr
// completed-result counter. The datapath is identical either way.
module barrett_reduce_pipe #(
  parameter int Q     = 3329,
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int K     = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef BARRETT_REDUCE_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [15:0]      done_count
`endif
);

  // M = floor(2^K / Q). The division is done at K+1 bits so that 2^K is representable.
  localparam int             KP1    = K + 1;
  localparam logic [K:0]     POW_K  = {1'b1, {K{1'b0}}};
  localparam logic [K:0]     M_FULL = POW_K / KP1'(Q);
  localparam int             M_W    = $clog2(M_FULL + 1);
  localparam logic [M_W-1:0] M      = M_W'(M_FULL);

  // The product keeps every bit so that qe is exact. r lives in OUT_W+1 bits
  // because it can reach 2Q-1.
  localparam int P_W = IN_W + M_W;
  localparam int R_W = OUT_W + 1;
  localparam int X_W = P_W + R_W;

  if (K < IN_W) begin : g_chk_k
    $error("barrett_reduce_pipe: K (%0d) must be >= IN_W (%0d)", K, IN_W);
  end
  if (longint'(Q) >= (64'd1 << OUT_W)) begin : g_chk_q_hi
    $error("barrett_reduce_pipe: Q (%0d) must be < 2^OUT_W", Q);
  end
  if (Q < 2 || (Q % 2) == 0) begin : g_chk_q_odd
    $error("barrett_reduce_pipe: Q (%0d) must be odd and >= 2", Q);
  end

  logic             stall;
  logic             en;

  logic             s1_valid;
  logic [IN_W-1:0]  s1_c;
  logic [P_W-1:0]   s1_p;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [R_W-1:0]   s2_r;
  logic [TAG_W-1:0] s2_tag;

  logic             s3_valid;
  logic [OUT_W-1:0] s3_data;
  logic [TAG_W-1:0] s3_tag;

  logic [P_W-1:0]   p_next;
  logic [P_W-1:0]   qe;
  logic [X_W-1:0]   qe_q;
  logic [R_W-1:0]   r_next;
  logic [R_W-1:0]   r_minus_q;
  logic [OUT_W-1:0] d_next;

  assign stall     = s3_valid && !out_ready;
  assign en        = !stall;
  assign in_ready  = en;

  assign out_valid = s3_valid;
  assign out_data  = s3_data;
  assign out_tag   = s3_tag;

  // Per-stage arithmetic. r is exact modulo 2^R_W, and because 0 <= r < 2Q < 2^R_W
  // the truncated difference equals the true remainder estimate.
  always_comb begin
    p_next    = P_W'(in_data) * P_W'(M);
    qe        = s1_p >> K;
    qe_q      = X_W'(qe) * X_W'(Q);
    r_next    = R_W'(X_W'(s1_c) - qe_q);
    r_minus_q = s2_r - R_W'(Q);
    d_next    = (s2_r >= R_W'(Q)) ? OUT_W'(r_minus_q) : OUT_W'(s2_r);
  end

  // Stage valid bits: shift on the global enable and clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // S1 datapath: operand, tag and full Barrett product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_c   <= '0;
      s1_p   <= '0;
      s1_tag <= '0;
    end else if (en) begin
      s1_c   <= in_data;
      s1_p   <= p_next;
      s1_tag <= in_tag;
    end
  end

  // S2 datapath: partial remainder in [0, 2Q).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_r   <= '0;
      s2_tag <= '0;
    end else if (en) begin
      s2_r   <= r_next;
      s2_tag <= s1_tag;
    end
  end

  // S3 datapath: final correction. These registers drive the outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_data <= '0;
      s3_tag  <= '0;
    end else if (en) begin
      s3_data <= d_next;
      s3_tag  <= s2_tag;
    end
  end

`ifdef BARRETT_REDUCE_STATS_EN
  // Completed-result counter. It saturates at all-ones, and a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_count <= '0;
    end else if (stats_clr) begin
      done_count <= '0;
    end else if (out_valid && out_ready && (done_count != 16'hFFFF)) begin
      done_count <= done_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Self-checking bench for barrett_reduce_pipe. The reference is plain c % Q on
// 64-bit integers, with a FIFO of expected (result, tag) pairs.
module tb_barrett_reduce_pipe;
  localparam int Q     = 3329;
  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
  localparam int K     = 32;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
`ifdef BARRETT_REDUCE_STATS_EN
  logic             stats_clr = 1'b0;
  logic [15:0]      done_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  barrett_reduce_pipe #(.Q(Q), .IN_W(IN_W), .OUT_W(OUT_W), .K(K), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef BARRETT_REDUCE_STATS_EN
    ,
    .stats_clr (stats_clr),
    .done_count(done_count)
`endif
  );

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic [TAG_W-1:0] t;
  } res_t;

  res_t             exp_q[$];
  res_t             got_q[$];
  int               got_cyc[$];
  res_t             e_r;
  res_t             g_r;
  res_t             p_r;
  int               cycle = 0;
  int               stall_seen = 0;
  logic             prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_d = '0;
  logic [TAG_W-1:0] prev_t = '0;

  function automatic logic [OUT_W-1:0] ref_mod(input logic [IN_W-1:0] c);
    longint unsigned v;
    v = 64'(c);
    return OUT_W'(v % 64'(Q));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cycle);
    end
  endtask

  // Compare process: runs on the falling edge, after the inputs have settled and away from the DUT edge.
  always @(negedge clk) begin
    cycle++;
    if (rst_n) begin
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        check("stall_hold_data", out_data, prev_d);
        check("stall_hold_tag", out_tag, prev_t);
      end
      if (out_valid && !out_ready) stall_seen++;
      if (out_valid && out_ready) begin
        g_r.d = out_data;
        g_r.t = out_tag;
        got_q.push_back(g_r);
        got_cyc.push_back(cycle);
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1'b1, 1'b0);
        end else begin
          e_r = exp_q.pop_front();
          check("out_data", out_data, e_r.d);
          check("out_tag", out_tag, e_r.t);
        end
      end
      if (in_valid && in_ready) begin
        p_r.d = ref_mod(in_data);
        p_r.t = in_tag;
        exp_q.push_back(p_r);
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_t     = out_tag;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word and holds it until it is accepted, giving up after a bounded number of cycles.
  task automatic send(input logic [IN_W-1:0] c, input logic [TAG_W-1:0] t);
    logic acc;
    int   guard;
    in_valid = 1'b1;
    in_data  = c;
    in_tag   = t;
    acc      = 1'b0;
    guard    = 0;
    while (!acc && guard < 1000) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      guard++;
    end
    check("send_accepted", acc, 1'b1);
  endtask

  // Returns the number of cycles from the handshake to the first out_valid.
  task automatic wait_out_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int base;
    int sent;
    int guard;
    int pick;
    logic acc;
    logic [IN_W-1:0] bvals[5];
    logic [OUT_W-1:0] bexp[5];

    check("model_pin_a", ref_mod(32'h12345678), 791);
    check("model_pin_b", ref_mod(32'hFFFFFFFF), 1352);
    check("model_pin_c", ref_mod(32'd6658), 0);

    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 0);
    check("reset_out_tag", out_tag, 0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("reset_in_ready", in_ready, 1'b1);

    // Single word: latency and literal result.
    got_q.delete();
    send(32'h12345678, 8'h5A);
    in_valid = 1'b0;
    wait_out_valid(lat);
    check("single_latency", lat, 3);
    check("single_data", out_data, 16'h0317);
    check("single_tag", out_tag, 8'h5A);
    repeat (4) tick();

    // Boundary values sent back to back.
    bvals = '{32'd0, 32'd3328, 32'd3329, 32'd6658, 32'hFFFFFFFF};
    bexp  = '{16'd0, 16'd3328, 16'd0, 16'd0, 16'h0548};
    got_q.delete();
    got_cyc.delete();
    for (int i = 0; i < 5; i++) send(bvals[i], TAG_W'(8'hB0 + i));
    in_valid = 1'b0;
    repeat (8) tick();
    check("bound_count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      check("bound_data", got_q[i].d, bexp[i]);
      check("bound_tag", got_q[i].t, 8'hB0 + i);
      check("bound_consecutive", got_cyc[i] - got_cyc[0], i);
    end

    // Backpressure: out_ready is held low for cycles 5 to 9 of a 10-word stream.
    got_q.delete();
    base = stall_seen;
    fork
      begin
        for (int i = 0; i < 10; i++) send(32'h00100000 * i + 32'd777 * i, TAG_W'(8'h10 + i));
        in_valid = 1'b0;
      end
      begin
        repeat (5) tick();
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
      end
    join
    repeat (8) tick();
    check("bp_stall_cycles", stall_seen - base, 5);
    check("bp_count", got_q.size(), 10);
    for (int i = 0; i < 10 && i < got_q.size(); i++) begin
      check("bp_order_tag", got_q[i].t, 8'h10 + i);
      check("bp_data", got_q[i].d, ref_mod(32'h00100000 * i + 32'd777 * i));
    end

    // Reset with three words in flight.
    got_q.delete();
    for (int i = 0; i < 3; i++) send(32'd5000 + i, TAG_W'(8'hC0 + i));
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_out_data", out_data, 0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    repeat (5) tick();
    check("midreset_no_stale", got_q.size(), 0);
    send(32'd9999, 8'hD1);
    in_valid = 1'b0;
    wait_out_valid(lat);
    check("post_reset_latency", lat, 3);
    check("post_reset_data", out_data, 16'd12);
    check("post_reset_tag", out_tag, 8'hD1);
    repeat (4) tick();

`ifdef BARRETT_REDUCE_STATS_EN
    do_reset();
    check("stats_reset", done_count, 0);
    for (int i = 0; i < 7; i++) send($urandom, TAG_W'(i));
    in_valid = 1'b0;
    repeat (6) tick();
    check("stats_seven", done_count, 7);
    send(32'd4242, 8'hE0);
    in_valid = 1'b0;
    wait_out_valid(lat);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("stats_clr_wins", done_count, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in_data = $urandom;
      in_tag  = TAG_W'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    check("stats_preload", done_count, 16'hFFFF);
    send(32'd1, 8'hE1);
    in_valid = 1'b0;
    repeat (6) tick();
    check("stats_saturate", done_count, 16'hFFFF);
`endif

    // Random soak with random in_valid and out_ready; boundary values are mixed in.
    sent  = 0;
    guard = 0;
    while (sent < 10000 && guard < 60000) begin
      pick = $urandom_range(0, 15);
      case (pick)
        0:       in_data = 32'd0;
        1:       in_data = 32'(Q - 1);
        2:       in_data = 32'(Q);
        3:       in_data = 32'hFFFFFFFF;
        default: in_data = $urandom;
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      in_tag    = TAG_W'(sent);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
      guard++;
    end
    check("soak_sent", sent, 10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    check("soak_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
